prog_loader: RTL and testbench

Parametrised boot loader that sits between the POCO core and its single-port instruction RAM.
- After `start`, it accepts a program stream over a valid/ready handshake and writes it into the RAM from `BASE_ADDR`, while holding the core in reset.
- On completion it releases the core and passes core memory traffic through to the RAM.
- It keeps a running checksum of the loaded image and supports reloading without a system reset.

---
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader between the POCO core and its instruction RAM: streams an image into RAM
// while the core is held in reset, then hands the RAM port over to the core.
module prog_loader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int LOAD_WORDS = 256,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_we,
    output logic              cpu_rst_n,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] csum
);

    // Stream handshake: a word transfers on a rising edge where s_valid && s_ready.
    // s_ready never depends on s_valid; s_valid may be raised at any time.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                s_ready_q, s_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                hs;

    assign hs = s_valid & s_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = BASE + cnt_q;
                    ram_din_d  = s_data;
                    cnt_d      = cnt_q + ADDR_W'(1);
                    csum_d     = csum_q + s_data;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they align with it.
        s_ready_d   = (state_d == S_LOAD);
        busy_d      = (state_d == S_LOAD) || (state_d == S_RELEASE);
        done_d      = (state_d == S_RUN);
        cpu_rst_n_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            csum_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Once running, the core owns the RAM port combinationally.
    assign ram_en    = (state_q == S_RUN) ? 1'b1     : ram_en_q;
    assign ram_we    = (state_q == S_RUN) ? cpu_we   : ram_we_q;
    assign ram_addr  = (state_q == S_RUN) ? cpu_addr : ram_addr_q;
    assign ram_din   = (state_q == S_RUN) ? cpu_din  : ram_din_q;

    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign csum      = csum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (16-bit address at 0x10, 4-bit address at 0xE)
// share one stimulus stream; a write monitor checks every RAM write against the image.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, cpu_we;
    logic [15:0] s_data, cpu_addr, cpu_din;

    logic        s_ready_a, cpu_rst_n_a, ram_en_a, ram_we_a, busy_a, done_a;
    logic [15:0] ram_addr_a, ram_din_a, csum_a;
    logic        s_ready_w, cpu_rst_n_w, ram_en_w, ram_we_w, busy_w, done_w;
    logic [3:0]  ram_addr_w;
    logic [15:0] ram_din_w, csum_w;

    prog_loader #(.DATA_W(16), .ADDR_W(16), .LOAD_WORDS(4), .BASE_ADDR(16'h0010)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_data(s_data), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_rst_n(cpu_rst_n_a), .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
        .ram_din(ram_din_a), .busy(busy_a), .done(done_a), .csum(csum_a)
    );

    prog_loader #(.DATA_W(16), .ADDR_W(4), .LOAD_WORDS(4), .BASE_ADDR(4'hE)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready_w),
        .s_data(s_data), .cpu_addr(cpu_addr[3:0]), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_rst_n(cpu_rst_n_w), .ram_en(ram_en_w), .ram_we(ram_we_w), .ram_addr(ram_addr_w),
        .ram_din(ram_din_w), .busy(busy_w), .done(done_w), .csum(csum_w)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    logic [19:0] exp_w_q[$];
    logic [15:0] last_csum = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loader-mode writes must appear exactly one cycle after each accepted word,
    // in image order, at BASE+index.
    initial begin
        bit prev_a, prev_w;
        logic [31:0] e;
        logic [19:0] ew;
        prev_a = 1'b0;
        prev_w = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_a = 1'b0;
                prev_w = 1'b0;
            end else begin
                if (!done_a) begin
                    check("a_we_after_hs", ram_we_a, prev_a);
                    check("a_en_eq_we", ram_en_a, ram_we_a);
                    if (ram_we_a) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL a_unexpected_write: got write at 0x%0h, required none", ram_addr_a);
                        end else begin
                            e = exp_q.pop_front();
                            check("a_write", {ram_addr_a, ram_din_a}, e);
                        end
                    end
                end
                if (!done_w) begin
                    check("w_we_after_hs", ram_we_w, prev_w);
                    check("w_en_eq_we", ram_en_w, ram_we_w);
                    if (ram_we_w) begin
                        if (exp_w_q.size() == 0) begin
                            n_total++;
                            $display("FAIL w_unexpected_write: got write at 0x%0h, required none", ram_addr_w);
                        end else begin
                            ew = exp_w_q.pop_front();
                            check("w_write", {ram_addr_w, ram_din_w}, ew);
                        end
                    end
                end
                prev_a = s_valid && s_ready_a;
                prev_w = s_valid && s_ready_w;
            end
        end
    end

    // driver tasks
    task automatic reset_checks(input string tag);
        check({tag, "_a_ready"}, s_ready_a, 0);
        check({tag, "_a_en"}, ram_en_a, 0);
        check({tag, "_a_we"}, ram_we_a, 0);
        check({tag, "_a_busy"}, busy_a, 0);
        check({tag, "_a_done"}, done_a, 0);
        check({tag, "_a_cpu_rst_n"}, cpu_rst_n_a, 0);
        check({tag, "_a_addr"}, ram_addr_a, 0);
        check({tag, "_a_din"}, ram_din_a, 0);
        check({tag, "_a_csum"}, csum_a, 0);
        check({tag, "_w_addr"}, ram_addr_w, 0);
        check({tag, "_w_we"}, ram_we_w, 0);
        check({tag, "_w_csum"}, csum_w, 0);
    endtask

    task automatic push_expected(input logic [3:0][15:0] img, input int n);
        logic [15:0] aa;
        logic [3:0]  aw;
        for (int k = 0; k < n; k++) begin
            aa = 16'h0010 + 16'(k);
            aw = 4'hE + 4'(k);
            exp_q.push_back({aa, img[k]});
            exp_w_q.push_back({aw, img[k]});
        end
    endtask

    // mode: 0 back-to-back, 1 one idle cycle between words, 2 random gaps
    task automatic do_load(input logic [3:0][15:0] img, input int mode, input bit sv_start,
                           input bit mid_start, input bit rel_start, input logic [15:0] exp_csum);
        int i, budget, first_cyc, gaps;
        bit hs;
        push_expected(img, 4);
        start = 1'b1;
        s_valid = sv_start;
        s_data = 16'hDEAD;
        tick();
        start = 1'b0;
        s_valid = 1'b0;
        check("entry_a_ready", s_ready_a, 1);
        check("entry_a_busy", busy_a, 1);
        check("entry_a_done", done_a, 0);
        check("entry_a_cpu_rst_n", cpu_rst_n_a, 0);
        check("entry_a_csum", csum_a, 0);
        check("entry_w_csum", csum_w, 0);
        i = 0;
        budget = 0;
        first_cyc = -1;
        while (i < 4 && budget < 64) begin
            gaps = (i == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                s_valid = 1'b0;
                s_data = 16'($urandom);
                tick();
            end
            start = mid_start && (i == 2);
            s_valid = 1'b1;
            s_data = img[i];
            @(negedge clk);
            hs = s_ready_a;
            check("load_a_ready", s_ready_a, 1);
            check("load_w_ready", s_ready_w, 1);
            if (hs && first_cyc < 0) first_cyc = cyc;
            tick();
            start = 1'b0;
            if (hs) i++;
            budget++;
        end
        check("load_words_accepted", i, 4);
        // RELEASE: extra valid words and start must be ignored
        s_valid = 1'b1;
        s_data = 16'hBEEF;
        start = rel_start;
        check("rel_a_ready", s_ready_a, 0);
        check("rel_a_busy", busy_a, 1);
        check("rel_a_done", done_a, 0);
        check("rel_a_cpu_rst_n", cpu_rst_n_a, 0);
        check("rel_a_csum", csum_a, exp_csum);
        check("rel_w_busy", busy_w, 1);
        check("rel_w_csum", csum_w, exp_csum);
        tick();
        start = 1'b0;
        s_valid = 1'b0;
        check("run_a_done", done_a, 1);
        check("run_a_cpu_rst_n", cpu_rst_n_a, 1);
        check("run_a_busy", busy_a, 0);
        check("run_a_ready", s_ready_a, 0);
        check("run_a_csum", csum_a, exp_csum);
        check("run_w_done", done_w, 1);
        check("run_w_cpu_rst_n", cpu_rst_n_w, 1);
        check("a_all_writes_seen", exp_q.size(), 0);
        check("w_all_writes_seen", exp_w_q.size(), 0);
        if (mode == 0) check("load_latency", cyc - first_cyc, 5);
        last_csum = exp_csum;
    endtask

    task automatic run_random(input int n);
        logic [3:0] aw;
        repeat (n) begin
            cpu_addr = 16'($urandom);
            cpu_din = 16'($urandom);
            cpu_we = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            #1;
            aw = cpu_addr[3:0];
            check("pt_rand_en", ram_en_a, 1);
            check("pt_rand_we", ram_we_a, cpu_we);
            check("pt_rand_addr", ram_addr_a, cpu_addr);
            check("pt_rand_din", ram_din_a, cpu_din);
            check("pt_rand_w_addr", ram_addr_w, aw);
            check("pt_rand_ready", s_ready_a, 0);
            check("pt_rand_csum_hold", csum_a, last_csum);
            tick();
        end
        cpu_we = 1'b0;
        s_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0][15:0] w;
        int               mode;
        bit               sv_start;
        bit               mid_start;
        bit               rel_start;
        logic [15:0]      exp_csum;
    } load_vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] din;
        logic        exp_en;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_din;
    } pt_vec_t;

    load_vec_t lv[4];
    pt_vec_t   pt[4];

    initial begin
        logic [3:0][15:0] img;
        logic [15:0] sum;
        logic [3:0]  aw;

        lv[0] = '{{16'hFFFF, 16'h0003, 16'h0002, 16'h0001}, 0, 1'b1, 1'b0, 1'b0, 16'h0005};
        lv[1] = '{{16'hFFFF, 16'h0003, 16'h0002, 16'h0001}, 1, 1'b0, 1'b0, 1'b0, 16'h0005};
        lv[2] = '{{16'h0001, 16'h1234, 16'h8000, 16'h8000}, 0, 1'b0, 1'b1, 1'b0, 16'h1235};
        lv[3] = '{{16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1, 1'b0, 1'b0, 1'b1, 16'h00A0};
        pt[0] = '{16'h0012, 1'b1, 16'hABCD, 1'b1, 1'b1, 16'h0012, 16'hABCD};
        pt[1] = '{16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h1234};
        pt[2] = '{16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
        pt[3] = '{16'h00F3, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h00F3, 16'hFFFF};

        rst_n = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 16'h0;
        cpu_addr = 16'h0;
        cpu_din = 16'h0;
        cpu_we = 1'b0;
        #3;
        reset_checks("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("idle_a_ready", s_ready_a, 0);
        check("idle_a_cpu_rst_n", cpu_rst_n_a, 0);
        s_valid = 1'b1;
        s_data = 16'h7777;
        repeat (2) begin
            tick();
            check("idle_valid_ignored", s_ready_a, 0);
        end
        s_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_load(lv[v].w, lv[v].mode, lv[v].sv_start, lv[v].mid_start, lv[v].rel_start,
                    lv[v].exp_csum);
            if (v == 0) begin
                for (int p = 0; p < 4; p++) begin
                    cpu_addr = pt[p].addr;
                    cpu_we = pt[p].we;
                    cpu_din = pt[p].din;
                    #1;
                    aw = pt[p].exp_addr[3:0];
                    check("pt_tbl_en", ram_en_a, pt[p].exp_en);
                    check("pt_tbl_we", ram_we_a, pt[p].exp_we);
                    check("pt_tbl_addr", ram_addr_a, pt[p].exp_addr);
                    check("pt_tbl_din", ram_din_a, pt[p].exp_din);
                    check("pt_tbl_w_addr", ram_addr_w, aw);
                    check("pt_tbl_w_we", ram_we_w, pt[p].exp_we);
                    tick();
                end
                cpu_we = 1'b0;
            end
            run_random(4);
        end

        // reset in the middle of a load
        img = {16'h0000, 16'h0000, 16'h2222, 16'h1111};
        push_expected(img, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_data = img[k];
            check("mid_a_ready", s_ready_a, 1);
            tick();
        end
        check("mid_write_visible", ram_we_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        exp_q.delete();
        exp_w_q.delete();
        s_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        reset_checks("post_rst_idle");
        s_valid = 1'b1;
        repeat (3) begin
            s_data = 16'($urandom);
            tick();
            check("post_rst_ready", s_ready_a, 0);
        end
        s_valid = 1'b0;

        // randomized images against the reference sum
        for (int r = 0; r < 3; r++) begin
            sum = 16'h0;
            for (int k = 0; k < 4; k++) begin
                img[k] = 16'($urandom);
                sum = sum + img[k];
            end
            do_load(img, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, sum);
            run_random(3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
